count_sequence_checker: RTL and testbench

COUNT_SEQUENCE_CHECKER -- requirements
Module: count_sequence_checker

---
 rtl/count_sequence_checker_if.sv | 29 ++
 rtl/count_sequence_checker.sv | 147 ++++++++++++++
 tb/tb_count_sequence_checker.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/count_sequence_checker_if.sv
// count_sequence_checker_if
// Groups the observed count and the checker's status outputs into one bundle.
//   q        : observed 4-bit count from the counter under test
//   locked   : checker is locked onto the count sequence
//   mismatch : one-cycle pulse per bad sample while locked
//   exp_q    : next expected count value
//   err_cnt  : total mismatches since reset, saturating
//   wrap_cnt : correct 15->0 transitions seen while locked, modulo 256
//   lost     : sticky, lock was lost at least once since reset
// master = counter side (drives q), slave = checker side (drives status).
interface count_sequence_checker_if;
    logic [3:0] q;
    logic       locked;
    logic       mismatch;
    logic [3:0] exp_q;
    logic [7:0] err_cnt;
    logic [7:0] wrap_cnt;
    logic       lost;

    modport master (
        output q,
        input  locked, mismatch, exp_q, err_cnt, wrap_cnt, lost
    );

    modport slave (
        input  q,
        output locked, mismatch, exp_q, err_cnt, wrap_cnt, lost
    );
endinterface

// File: rtl/count_sequence_checker.sv
// count_sequence_checker
// Watches a free-running 4-bit up-counter and reports whether it steps by +1
// (mod 16) every clock. Locks after LOCK_LEN consecutive correct increments,
// drops lock after ERR_LIMIT consecutive mismatches.
// Ports:
//   clk  : single clock, all state updates on posedge
//   rst  : synchronous, active-high reset
//   bus  : count_sequence_checker_if.slave (q in; locked, mismatch, exp_q,
//          err_cnt, wrap_cnt, lost out; all outputs registered)
// Build option:
//   COUNT_CHECKER_STALL_EN - when defined, a repeated value (q == prev) while
//   locked is a stall rather than a mismatch. Port list is the same either way.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | first sample after reset, capture it as prev
// ACQUIRE | counting consecutive correct increments toward LOCK_LEN
// LOCKED  | tracking; bad samples pulse mismatch and count toward ERR_LIMIT
// LOST    | single cycle after lock loss, then back to ACQUIRE
module count_sequence_checker #(
    parameter int LOCK_LEN  = 2,
    parameter int ERR_LIMIT = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    count_sequence_checker_if.slave  bus
);

    localparam logic [3:0] LOCK_LEN_W  = 4'(LOCK_LEN);
    localparam logic [3:0] ERR_LIMIT_W = 4'(ERR_LIMIT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2,
        LOST    = 2'd3
    } state_t;

    state_t     state;
    logic [3:0] prev;
    logic [3:0] run;
    logic [3:0] consec;

    logic       locked_r;
    logic       mismatch_r;
    logic [3:0] exp_q_r;
    logic [7:0] err_cnt_r;
    logic [7:0] wrap_cnt_r;
    logic       lost_r;

    logic [3:0] nxt;
    logic [3:0] run_inc;
    logic [3:0] consec_inc;
    logic       good;

    assign nxt        = prev + 4'd1;
    assign run_inc    = run + 4'd1;
    assign consec_inc = consec + 4'd1;
    assign good       = (bus.q == nxt);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            prev       <= 4'd0;
            run        <= 4'd0;
            consec     <= 4'd0;
            locked_r   <= 1'b0;
            mismatch_r <= 1'b0;
            exp_q_r    <= 4'd0;
            err_cnt_r  <= 8'd0;
            wrap_cnt_r <= 8'd0;
            lost_r     <= 1'b0;
        end else begin
            mismatch_r <= 1'b0;
            // prev follows the observed value in every state, so exp_q can be
            // computed straight from the sample and stay registered.
            prev       <= bus.q;
            exp_q_r    <= bus.q + 4'd1;

            case (state)
                IDLE: begin
                    run   <= 4'd0;
                    state <= ACQUIRE;
                end

                ACQUIRE: begin
                    if (good) begin
                        if (run_inc == LOCK_LEN_W) begin
                            run      <= 4'd0;
                            consec   <= 4'd0;
                            locked_r <= 1'b1;
                            state    <= LOCKED;
                        end else begin
                            run <= run_inc;
                        end
                    end else begin
                        run <= 4'd0;
                    end
                end

                LOCKED: begin
                    if (good) begin
                        consec <= 4'd0;
                        // good with prev == 15 means the sample is 0
                        if (prev == 4'hF) begin
                            wrap_cnt_r <= wrap_cnt_r + 8'd1;
                        end
`ifdef COUNT_CHECKER_STALL_EN
                    end else if (bus.q == prev) begin
                        consec <= consec;
`endif
                    end else begin
                        mismatch_r <= 1'b1;
                        if (err_cnt_r != 8'hFF) begin
                            err_cnt_r <= err_cnt_r + 8'd1;
                        end
                        if (consec_inc == ERR_LIMIT_W) begin
                            consec   <= 4'd0;
                            locked_r <= 1'b0;
                            lost_r   <= 1'b1;
                            state    <= LOST;
                        end else begin
                            consec <= consec_inc;
                        end
                    end
                end

                LOST: begin
                    run   <= 4'd0;
                    state <= ACQUIRE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.locked   = locked_r;
    assign bus.mismatch = mismatch_r;
    assign bus.exp_q    = exp_q_r;
    assign bus.err_cnt  = err_cnt_r;
    assign bus.wrap_cnt = wrap_cnt_r;
    assign bus.lost     = lost_r;

endmodule

// File: tb/tb_count_sequence_checker.sv
// Directed, table-driven bench for count_sequence_checker (LOCK_LEN=2,
// ERR_LIMIT=3). Each row gives the inputs for one clock and the outputs
// expected one edge later; a hand-written loop then drives error saturation.
module tb_count_sequence_checker;

`ifdef COUNT_CHECKER_STALL_EN
    localparam bit STALL = 1'b1;
`else
    localparam bit STALL = 1'b0;
`endif

    typedef struct {
        logic       rst;
        logic [3:0] q;
        logic       locked;
        logic       mismatch;
        logic [3:0] exp_q;
        logic [7:0] err_cnt;
        logic [7:0] wrap_cnt;
        logic       lost;
    } vec_t;

    logic clk;
    logic rst;
    count_sequence_checker_if bus ();

    count_sequence_checker #(.LOCK_LEN(2), .ERR_LIMIT(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_vec;
    int   n_bad;
    vec_t vq[$];

    task automatic add(input logic r, input logic [3:0] qv, input logic l,
                       input logic m, input logic [3:0] e, input logic [7:0] ec,
                       input logic [7:0] wc, input logic ls);
        vec_t v;
        v.rst = r; v.q = qv; v.locked = l; v.mismatch = m; v.exp_q = e;
        v.err_cnt = ec; v.wrap_cnt = wc; v.lost = ls;
        vq.push_back(v);
    endtask

    task automatic check(input string name, input vec_t e);
        n_vec++;
        if (bus.locked !== e.locked || bus.mismatch !== e.mismatch ||
            bus.exp_q !== e.exp_q || bus.err_cnt !== e.err_cnt ||
            bus.wrap_cnt !== e.wrap_cnt || bus.lost !== e.lost) begin
            n_bad++;
            $display("FAIL %s: got locked=%0b mm=%0b exp_q=%0d err=%0d wrap=%0d lost=%0b, want locked=%0b mm=%0b exp_q=%0d err=%0d wrap=%0d lost=%0b",
                     name, bus.locked, bus.mismatch, bus.exp_q, bus.err_cnt,
                     bus.wrap_cnt, bus.lost, e.locked, e.mismatch, e.exp_q,
                     e.err_cnt, e.wrap_cnt, e.lost);
        end
    endtask

    task automatic apply(input vec_t v, input string name);
        rst   = v.rst;
        bus.q = v.q;
        @(posedge clk);
        #1;
        check(name, v);
    endtask

    initial begin
        vec_t       v;
        logic [3:0] prev;
        int         errs;
        int         wraps;
        logic [3:0] q1, q2, q3;

        n_vec = 0;
        n_bad = 0;
        rst   = 1'b1;
        bus.q = 4'd0;

        //  rst  q  lock mm exp err wrap lost
        add(1, 5,  0, 0,  0, 0, 0, 0);   // reset, q ignored
        add(1, 9,  0, 0,  0, 0, 0, 0);
        add(0, 0,  0, 0,  1, 0, 0, 0);   // IDLE captures 0
        add(0, 1,  0, 0,  2, 0, 0, 0);   // run=1
        add(0, 2,  1, 0,  3, 0, 0, 0);   // run=2 -> LOCKED
        add(0, 3,  1, 0,  4, 0, 0, 0);
        add(0, 4,  1, 0,  5, 0, 0, 0);
        add(0, 5,  1, 0,  6, 0, 0, 0);
        add(0, 9,  1, 1, 10, 1, 0, 0);   // single mismatch
        add(0, 10, 1, 0, 11, 1, 0, 0);   // resynchronised, correct
        add(0, 11, 1, 0, 12, 1, 0, 0);
        add(0, 12, 1, 0, 13, 1, 0, 0);
        add(0, 13, 1, 0, 14, 1, 0, 0);
        add(0, 14, 1, 0, 15, 1, 0, 0);
        add(0, 15, 1, 0,  0, 1, 0, 0);
        add(0, 0,  1, 0,  1, 1, 1, 0);   // 15->0 wrap counted
        add(0, 1,  1, 0,  2, 1, 1, 0);
        add(0, 2,  1, 0,  3, 1, 1, 0);
        add(0, 3,  1, 0,  4, 1, 1, 0);
        add(0, 4,  1, 0,  5, 1, 1, 0);
        add(0, 5,  1, 0,  6, 1, 1, 0);
        add(0, 9,  1, 1, 10, 2, 1, 0);   // bad 1 of 3
        add(0, 2,  1, 1,  3, 3, 1, 0);   // bad 2 of 3
        add(0, 12, 0, 1, 13, 4, 1, 1);   // bad 3 -> LOST
        add(0, 13, 0, 0, 14, 4, 1, 1);   // LOST cycle
        add(0, 14, 0, 0, 15, 4, 1, 1);   // ACQUIRE run=1
        add(0, 15, 1, 0,  0, 4, 1, 1);   // run=2 -> relocked, lost sticky
        add(0, 0,  1, 0,  1, 4, 2, 1);
        add(0, 1,  1, 0,  2, 4, 2, 1);
        add(0, 2,  1, 0,  3, 4, 2, 1);
        add(0, 3,  1, 0,  4, 4, 2, 1);
        add(0, 4,  1, 0,  5, 4, 2, 1);
        add(0, 5,  1, 0,  6, 4, 2, 1);
        add(0, 6,  1, 0,  7, 4, 2, 1);
        add(0, 7,  1, 0,  8, 4, 2, 1);
        add(0, 7,  1, STALL ? 1'b0 : 1'b1, 8, STALL ? 8'd4 : 8'd5, 2, 1); // repeat
        add(0, 8,  1, 0,  9, STALL ? 8'd4 : 8'd5, 2, 1);
        add(1, 3,  0, 0,  0, 0, 0, 0);   // mid-operation reset
        add(0, 0,  0, 0,  1, 0, 0, 0);
        add(0, 1,  0, 0,  2, 0, 0, 0);
        add(0, 2,  1, 0,  3, 0, 0, 0);   // relock on 3rd sample

        foreach (vq[i]) begin
            apply(vq[i], $sformatf("row%0d", i));
        end

        // Two bad samples then one good keeps lock (below ERR_LIMIT) while
        // err_cnt climbs past 255 and must saturate.
        prev  = 4'd2;
        errs  = 0;
        wraps = 0;
        for (int t = 0; t < 130; t++) begin
            q1 = prev + 4'd5;
            q2 = q1 + 4'd5;
            q3 = q2 + 4'd1;

            errs++;
            v = '{1'b0, q1, 1'b1, 1'b1, q1 + 4'd1, 8'((errs > 255) ? 255 : errs),
                  8'(wraps), 1'b0};
            apply(v, $sformatf("sat%0d_a", t));

            errs++;
            v = '{1'b0, q2, 1'b1, 1'b1, q2 + 4'd1, 8'((errs > 255) ? 255 : errs),
                  8'(wraps), 1'b0};
            apply(v, $sformatf("sat%0d_b", t));

            if (q2 == 4'hF) wraps++;
            v = '{1'b0, q3, 1'b1, 1'b0, q3 + 4'd1, 8'((errs > 255) ? 255 : errs),
                  8'(wraps), 1'b0};
            apply(v, $sformatf("sat%0d_c", t));

            prev = q3;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
